equiv_stim_gen: RTL and testbench

Stimulus driver and result collector for the dual-instance equivalence harness. It generates reproducible pseudo-random input vectors for the two design copies (wire0..wire4) from a 32-bit Galois LFSR. It holds each vector for a settle window, then compares the two copies' outputs and records the first mismatch. The block sits beside the harness and drives its inputs from a start/done run handshake.

---
 rtl/equiv_stim_gen_if.sv | 49 ++++
 rtl/equiv_stim_gen.sv | 147 ++++++++++++++
 tb/tb_equiv_stim_gen.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/equiv_stim_gen_if.sv
// Run/stimulus/result bundle between the equivalence stimulus
// generator and the dual-instance harness it drives.
interface equiv_stim_gen_if;
  logic               start;
  logic [90:0]        y_1;
  logic [90:0]        y_2;
  logic signed [10:0] wire0;
  logic [19:0]        wire1;
  logic [16:0]        wire2;
  logic signed [16:0] wire3;
  logic [6:0]         wire4;
  logic               busy;
  logic               done;
  logic [15:0]        vec_idx;
  logic               mismatch;
  logic [15:0]        fail_idx;

  modport master (
    input  start,
    input  y_1,
    input  y_2,
    output wire0,
    output wire1,
    output wire2,
    output wire3,
    output wire4,
    output busy,
    output done,
    output vec_idx,
    output mismatch,
    output fail_idx
  );

  modport slave (
    output start,
    output y_1,
    output y_2,
    input  wire0,
    input  wire1,
    input  wire2,
    input  wire3,
    input  wire4,
    input  busy,
    input  done,
    input  vec_idx,
    input  mismatch,
    input  fail_idx
  );
endinterface

// File: rtl/equiv_stim_gen.sv
// LFSR-driven stimulus generator and first-mismatch recorder
// for a dual-instance equivalence harness.
module equiv_stim_gen #(
  parameter logic [31:0] SEED         = 32'h0000_0001,
  parameter int          NUM_VEC      = 1024,
  parameter int          SETTLE       = 2,
  parameter int          STOP_ON_FAIL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  equiv_stim_gen_if.master bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GEN0  = 3'd1;
  localparam logic [2:0] S_GEN1  = 3'd2;
  localparam logic [2:0] S_GEN2  = 3'd3;
  localparam logic [2:0] S_APPLY = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [31:0] POLY = 32'h8020_0003;
  localparam logic [31:0] SEED_EFF =
    (SEED == 32'h0) ? 32'h1 : SEED;
  localparam int CW =
    (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE - 1);
  localparam logic [15:0] VEC_LAST = 16'(NUM_VEC - 1);
  localparam bit STOP = (STOP_ON_FAIL != 0);

  logic [2:0]         r_state;
  logic [31:0]        r_lfsr;
  logic [31:0]        r_w0;
  logic [31:0]        r_w1;
  logic [CW-1:0]      r_cnt;
  logic signed [10:0] r_wire0;
  logic [19:0]        r_wire1;
  logic [16:0]        r_wire2;
  logic signed [16:0] r_wire3;
  logic [6:0]         r_wire4;
  logic               r_busy;
  logic               r_done;
  logic [15:0]        r_vidx;
  logic               r_mm;
  logic [15:0]        r_fidx;

  logic [31:0] w_step;
  logic [71:0] w_vec;
  logic        w_last;
  logic        w_diff;
  logic        w_end;

  assign w_step = r_lfsr[0] ? ((r_lfsr >> 1) ^ POLY)
                            : (r_lfsr >> 1);
  // Third word is taken straight from the step so all
  // five outputs load on the GEN2 -> APPLY edge together.
  assign w_vec  = {w_step[7:0], r_w1, r_w0};
  assign w_last = (r_cnt == SET_LAST);
  assign w_diff = (bus.y_1 != bus.y_2);
  assign w_end  = (STOP && w_diff) || (r_vidx == VEC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_lfsr  <= SEED_EFF;
      r_w0    <= '0;
      r_w1    <= '0;
      r_cnt   <= '0;
      r_wire0 <= '0;
      r_wire1 <= '0;
      r_wire2 <= '0;
      r_wire3 <= '0;
      r_wire4 <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_vidx  <= '0;
      r_mm    <= 1'b0;
      r_fidx  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_state <= S_GEN0;
            r_lfsr  <= SEED_EFF;
            r_vidx  <= '0;
            r_mm    <= 1'b0;
            r_fidx  <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_GEN0: begin
          r_lfsr  <= w_step;
          r_w0    <= w_step;
          r_state <= S_GEN1;
        end
        S_GEN1: begin
          r_lfsr  <= w_step;
          r_w1    <= w_step;
          r_state <= S_GEN2;
        end
        S_GEN2: begin
          r_lfsr  <= w_step;
          r_wire0 <= $signed(w_vec[10:0]);
          r_wire1 <= w_vec[30:11];
          r_wire2 <= w_vec[47:31];
          r_wire3 <= $signed(w_vec[64:48]);
          r_wire4 <= w_vec[71:65];
          r_cnt   <= '0;
          r_state <= S_APPLY;
        end
        S_APPLY: begin
          if (!w_last) begin
            r_cnt <= r_cnt + 1'b1;
          end else begin
            if (w_diff && !r_mm) begin
              r_mm   <= 1'b1;
              r_fidx <= r_vidx;
            end
            if (w_end) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_vidx  <= r_vidx + 16'd1;
              r_state <= S_GEN0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.wire0    = r_wire0;
  assign bus.wire1    = r_wire1;
  assign bus.wire2    = r_wire2;
  assign bus.wire3    = r_wire3;
  assign bus.wire4    = r_wire4;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.vec_idx  = r_vidx;
  assign bus.mismatch = r_mm;
  assign bus.fail_idx = r_fidx;

endmodule

// File: tb/tb_equiv_stim_gen.sv
// Scoreboard bench: one stop-on-fail and one run-all instance
// driven with the same seed, checked against a vector model.
module tb_equiv_stim_gen;
  localparam int N = 8;
  localparam int S = 2;
  localparam int P = 3 + S;
  localparam logic [31:0] SD = 32'h0000_0001;

  typedef struct packed {
    logic [71:0] vec;
    logic        busy;
    logic        done;
    logic [15:0] vidx;
    logic        mm;
    logic [15:0] fidx;
  } obs_t;

  typedef struct {
    int    cyc;
    obs_t  exp;
    obs_t  msk;
    string nm;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [90:0] y1 = '0;
  logic [7:0]  inj_a = '0;
  logic [7:0]  inj_b = '0;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  ent_t        q0[$];
  ent_t        q1[$];
  logic [71:0] prev[2];
  obs_t        o0;
  obs_t        o1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  equiv_stim_gen_if ia();
  equiv_stim_gen_if ib();

  assign ia.start = start;
  assign ib.start = start;
  assign ia.y_1 = y1;
  assign ib.y_1 = y1;
  assign ia.y_2 = y1 ^ {90'd0,
    ia.busy & inj_a[ia.vec_idx[2:0]]};
  assign ib.y_2 = y1 ^ {90'd0,
    ib.busy & inj_b[ib.vec_idx[2:0]]};

  equiv_stim_gen #(
    .SEED(SD), .NUM_VEC(N), .SETTLE(S),
    .STOP_ON_FAIL(1)
  ) u_a (.clk(clk), .rst_n(rst_n), .bus(ia));

  equiv_stim_gen #(
    .SEED(SD), .NUM_VEC(N), .SETTLE(S),
    .STOP_ON_FAIL(0)
  ) u_b (.clk(clk), .rst_n(rst_n), .bus(ib));

  assign o0 = {ia.wire4, ia.wire3, ia.wire2, ia.wire1,
               ia.wire0, ia.busy, ia.done, ia.vec_idx,
               ia.mismatch, ia.fail_idx};
  assign o1 = {ib.wire4, ib.wire3, ib.wire2, ib.wire1,
               ib.wire0, ib.busy, ib.done, ib.vec_idx,
               ib.mismatch, ib.fail_idx};

  function automatic logic [31:0] lstep(
    input logic [31:0] s);
    if (s[0]) return (s >> 1) ^ 32'h8020_0003;
    return s >> 1;
  endfunction

  function automatic obs_t mk(input bit v, input bit b,
    input bit dn, input bit vi, input bit m, input bit f);
    obs_t r;
    r = '0;
    if (v)  r.vec  = '1;
    if (b)  r.busy = 1'b1;
    if (dn) r.done = 1'b1;
    if (vi) r.vidx = '1;
    if (m)  r.mm   = 1'b1;
    if (f)  r.fidx = '1;
    return r;
  endfunction

  task automatic add(input int d, input int c,
    input string nm, input obs_t ex, input obs_t m);
    ent_t e;
    e.cyc = c;
    e.nm  = nm;
    e.exp = ex;
    e.msk = m;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic chk(input int d, input ent_t e,
    input obs_t a);
    n_chk++;
    if (e.cyc == cyc && ((a ^ e.exp) & e.msk) == '0)
      n_pass++;
    else
      $display("FAIL %s dut%0d cyc %0d/%0d got %h want %h",
        e.nm, d, cyc, e.cyc, a & e.msk, e.exp & e.msk);
  endtask

  always @(negedge clk) begin
    while (q0.size() > 0 && q0[0].cyc <= cyc)
      chk(0, q0.pop_front(), o0);
    while (q1.size() > 0 && q1[0].cyc <= cyc)
      chk(1, q1.pop_front(), o1);
  end

  task automatic run(input logic [7:0] ma,
    input logic [7:0] mb, input bit poke, input int rv);
    logic [71:0] vecs[N];
    logic [31:0] s, w0, w1, w2;
    logic [7:0]  m;
    obs_t        x;
    int          e0, edm, f, last, ed;
    s = (SD == 0) ? 32'h1 : SD;
    for (int k = 0; k < N; k++) begin
      s = lstep(s); w0 = s;
      s = lstep(s); w1 = s;
      s = lstep(s); w2 = s;
      vecs[k] = {w2[7:0], w1, w0};
    end
    y1 = 91'({$urandom(), $urandom(), $urandom()});
    inj_a = ma;
    inj_b = mb;
    @(negedge clk);
    start = 1'b1;
    e0 = cyc + 1;
    edm = 0;
    for (int d = 0; d < 2; d++) begin
      m = (d == 0) ? ma : mb;
      f = -1;
      for (int i = N - 1; i >= 0; i--) if (m[i]) f = i;
      last = (d == 0 && f >= 0) ? f : N - 1;
      ed = e0 + P * (last + 1);
      x = '0;
      x.busy = 1'b1;
      add(d, e0, "busy_rise", x, mk(0, 1, 1, 1, 1, 1));
      x.vec = prev[d];
      add(d, e0 + 2, "vec_hold", x, mk(1, 0, 0, 0, 0, 0));
      for (int k = 0; k <= last; k++) begin
        if (rv >= 0 && k > rv) break;
        x = '0;
        x.vec = vecs[k];
        x.busy = 1'b1;
        x.vidx = 16'(k);
        add(d, e0 + 3 + P * k, "vec_first", x,
          mk(1, 1, 0, 1, 0, 0));
        if (k != rv)
          add(d, e0 + 2 + S + P * k, "vec_last", x,
            mk(1, 1, 0, 1, 0, 0));
      end
      if (rv >= 0) begin
        add(d, e0 + 4 + P * rv, "async_rst", '0,
          mk(1, 1, 1, 1, 1, 1));
        prev[d] = '0;
      end else begin
        x = '0;
        x.vec  = vecs[last];
        x.done = 1'b1;
        x.vidx = 16'(last);
        x.mm   = (f >= 0);
        x.fidx = (f >= 0) ? 16'(f) : 16'd0;
        add(d, ed, "done", x, mk(1, 1, 1, 1, 1, 1));
        add(d, ed + 1, "done_hold", x, mk(1, 1, 1, 1, 1, 1));
        prev[d] = vecs[last];
        if (ed > edm) edm = ed;
      end
    end
    @(negedge clk);
    start = 1'b0;
    if (rv >= 0) begin
      while (cyc < e0 + 3 + P * rv) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
    end else begin
      while (cyc < edm + 2) begin
        @(negedge clk);
        start = poke && (cyc == e0 + 6 || cyc == edm - 1);
      end
      start = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    prev[0] = '0;
    prev[1] = '0;
    @(negedge clk);
    add(0, cyc + 1, "reset", '0, mk(1, 1, 1, 1, 1, 1));
    add(1, cyc + 1, "reset", '0, mk(1, 1, 1, 1, 1, 1));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run(8'h00, 8'h00, 1'b1, -1);
    run(8'h00, 8'h00, 1'b0, -1);
    run(8'h04, 8'h0C, 1'b0, -1);
    run(8'($urandom()), 8'($urandom()), 1'b0, -1);
    run(8'h00, 8'h00, 1'b0, 5);
    run(8'h00, 8'h00, 1'b0, -1);
    repeat (3) @(negedge clk);
    if (q0.size() + q1.size() > 0) begin
      n_chk += q0.size() + q1.size();
      $display("FAIL pending %0d checks never reached",
        q0.size() + q1.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
